// File: rtl/key_event_ctrl.sv
// key_event_ctrl: four active-low keys are synchronized and debounced.
// Each accepted press raises a one-cycle press event. The events feed a
// small Avalon-MM register block (DATA, MASK, EDGE, COUNT) and a level IRQ.
//
// Bus handshake: there is no wait-state or valid/ready flow control. A write
// is accepted on any rising edge where chipselect==1 and write_n==0. readdata
// is registered every cycle from the addressed register whatever chipselect
// is, so read data is valid one cycle after address is presented.
module key_event_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic [3:0]  in_port,
    output logic        irq
);

    localparam logic [CNT_W-1:0] TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] ADDR_DATA  = 2'd0;
    localparam logic [1:0] ADDR_MASK  = 2'd1;
    localparam logic [1:0] ADDR_EDGE  = 2'd2;
    localparam logic [1:0] ADDR_COUNT = 2'd3;

    logic [3:0]       r_sync1;
    logic [3:0]       r_sync2;
    logic [3:0]       r_stable;
    logic [CNT_W-1:0] r_cnt [4];
    logic [3:0]       r_mask;
    logic [3:0]       r_edge;
    logic [7:0]       r_count;
    logic [31:0]      r_readdata;
    logic             r_irq;

    logic [3:0]       w_term;
    logic [3:0]       w_press;
    logic [7:0]       w_press_num;
    logic             w_wr;
    logic [3:0]       w_edge_clr;
    logic [7:0]       w_count_base;
    logic             w_unused;

    // Upper write-data bits have no register behind them.
    assign w_unused = ^writedata[31:4];

    assign w_wr = chipselect & ~write_n;

    // A key's terminal count is reached while its synced level still
    // disagrees with the accepted level. The accepted level flips on that
    // edge. A press is such a flip from 1 to 0. Its event lines up with the
    // edge where stable changes, so DATA and EDGE/COUNT update together.
    always_comb begin
        w_term  = '0;
        w_press = '0;
        for (int i = 0; i < 4; i++) begin
            w_term[i]  = (r_sync2[i] != r_stable[i]) && (r_cnt[i] == TERM);
            w_press[i] = w_term[i] && r_stable[i];
        end
    end

    assign w_press_num = 8'(w_press[0]) + 8'(w_press[1])
                       + 8'(w_press[2]) + 8'(w_press[3]);

    assign w_edge_clr   = (w_wr && address == ADDR_EDGE) ? writedata[3:0] : 4'h0;
    assign w_count_base = (w_wr && address == ADDR_COUNT) ? 8'h00 : r_count;

    // Two-flop synchronizer. It idles high, meaning released, out of reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 4'hF;
            r_sync2 <= 4'hF;
        end else begin
            r_sync1 <= in_port;
            r_sync2 <= r_sync1;
        end
    end

    // Per-key debounce. Any agreement with the accepted level zeroes the
    // count, so a bounce earns no partial credit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stable <= 4'hF;
            for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (r_sync2[i] == r_stable[i]) begin
                    r_cnt[i] <= '0;
                end else if (w_term[i]) begin
                    r_stable[i] <= r_sync2[i];
                    r_cnt[i]    <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Writable registers. In EDGE a press sets its bit ahead of a
    // same-cycle W1C. COUNT adds this cycle's presses after any clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mask  <= 4'h0;
            r_edge  <= 4'h0;
            r_count <= 8'h00;
        end else begin
            if (w_wr && address == ADDR_MASK) r_mask <= writedata[3:0];
            r_edge  <= (r_edge & ~w_edge_clr) | w_press;
            r_count <= w_count_base + w_press_num;
        end
    end

    // Registered read mux. It runs every cycle regardless of chipselect.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_readdata <= 32'h0;
        end else begin
            case (address)
                ADDR_DATA:  r_readdata <= {28'h0, r_stable};
                ADDR_MASK:  r_readdata <= {28'h0, r_mask};
                ADDR_EDGE:  r_readdata <= {28'h0, r_edge};
                ADDR_COUNT: r_readdata <= {24'h0, r_count};
                default:    r_readdata <= 32'h0;
            endcase
        end
    end

    // Level interrupt from the masked sticky press bits, one cycle behind them.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_irq <= 1'b0;
        else          r_irq <= |(r_edge & r_mask);
    end

    assign readdata = r_readdata;
    assign irq      = r_irq;

endmodule

// File: tb/tb_key_event_ctrl.sv
// Directed bench for key_event_ctrl with DEBOUNCE_CYCLES=8.
// A table of {inputs, expected} records covers the plain register paths.
// Hand-written sequences cover bounce, collisions, wrap and reset.
module tb_key_event_ctrl;

    localparam int DC = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [3:0]  in_port;
    logic        irq;

    int n_checks = 0;
    int n_errors = 0;

    key_event_ctrl #(.DEBOUNCE_CYCLES(DC), .CNT_W(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .irq        (irq)
    );

    // clock / reset block
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  in_val;
        logic        wr_en;
        logic [1:0]  wr_addr;
        logic [31:0] wr_data;
        int          wait_cyc;
        logic [1:0]  rd_addr;
        logic [31:0] exp_data;
        logic        exp_irq;
    } vec_t;

    vec_t vecs [14];

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        address = a;
        tick();
        d = readdata;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_reg(input string name, input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        check(name, d, exp);
    endtask

    initial begin
        logic [31:0] d;
        int          n;
        bit          seen;

        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
        in_port    = 4'hF;

        // name, in, wr_en, wr_addr, wr_data, wait, rd_addr, exp_data, exp_irq
        vecs[0]  = '{"idle_data",     4'hF, 1'b0, 2'd0, 32'h0,        3, 2'd0, 32'hF, 1'b0};
        vecs[1]  = '{"early_data",    4'hE, 1'b0, 2'd0, 32'h0,        5, 2'd0, 32'hF, 1'b0};
        vecs[2]  = '{"press_data",    4'hE, 1'b0, 2'd0, 32'h0,       10, 2'd0, 32'hE, 1'b0};
        vecs[3]  = '{"press_edge",    4'hE, 1'b0, 2'd0, 32'h0,        0, 2'd2, 32'h1, 1'b0};
        vecs[4]  = '{"press_count",   4'hE, 1'b0, 2'd0, 32'h0,        0, 2'd3, 32'h1, 1'b0};
        vecs[5]  = '{"data_ro",       4'hE, 1'b1, 2'd0, 32'hFFFFFFFF, 20, 2'd0, 32'hE, 1'b0};
        vecs[6]  = '{"held_count",    4'hE, 1'b0, 2'd0, 32'h0,        0, 2'd3, 32'h1, 1'b0};
        vecs[7]  = '{"release_count", 4'hF, 1'b0, 2'd0, 32'h0,       15, 2'd3, 32'h1, 1'b0};
        vecs[8]  = '{"release_data",  4'hF, 1'b0, 2'd0, 32'h0,        0, 2'd0, 32'hF, 1'b0};
        vecs[9]  = '{"mask_wr",       4'hF, 1'b1, 2'd1, 32'h2,        0, 2'd1, 32'h2, 1'b0};
        vecs[10] = '{"key1_edge",     4'hD, 1'b0, 2'd0, 32'h0,       15, 2'd2, 32'h3, 1'b1};
        vecs[11] = '{"edge_w1c",      4'hD, 1'b1, 2'd2, 32'h2,        0, 2'd2, 32'h1, 1'b0};
        vecs[12] = '{"count_clr",     4'hF, 1'b1, 2'd3, 32'hAB,      15, 2'd3, 32'h0, 1'b0};
        vecs[13] = '{"edge_clr",      4'hF, 1'b1, 2'd2, 32'hF,        0, 2'd2, 32'h0, 1'b0};

        // reset state
        #2;
        check("rst_readdata", readdata, 32'h0);
        check("rst_irq", {31'h0, irq}, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        check_reg("rst_data", 2'd0, 32'hF);
        check_reg("rst_mask", 2'd1, 32'h0);
        check_reg("rst_edge", 2'd2, 32'h0);
        check_reg("rst_count", 2'd3, 32'h0);

        // table-driven vectors
        for (int v = 0; v < 14; v++) begin
            in_port = vecs[v].in_val;
            if (vecs[v].wr_en) bus_write(vecs[v].wr_addr, vecs[v].wr_data);
            repeat (vecs[v].wait_cyc) tick();
            bus_read(vecs[v].rd_addr, d);
            check(vecs[v].name, d, vecs[v].exp_data);
            check({vecs[v].name, "_irq"}, {31'h0, irq}, {31'h0, vecs[v].exp_irq});
        end

        // bounce: low 5, high 2, low until accepted; timing from final low edge
        in_port = 4'hE;
        repeat (5) tick();
        in_port = 4'hF;
        repeat (2) tick();
        in_port = 4'hE;
        address = 2'd0;
        n = 0;
        seen = 1'b0;
        for (int t = 1; t <= 40 && !seen; t++) begin
            tick();
            if (readdata[3:0] == 4'hE) begin
                seen = 1'b1;
                n = t;
            end
        end
        check("bounce_seen", {31'h0, seen}, 32'h1);
        check("bounce_timing_ok", {31'h0, (n >= 10 && n <= 12)}, 32'h1);
        repeat (5) tick();
        check_reg("bounce_count", 2'd3, 32'h1);
        check_reg("bounce_edge", 2'd2, 32'h1);
        in_port = 4'hF;
        repeat (15) tick();

        // W1C of EDGE[2] on the same edge key2's press lands
        in_port = 4'hB;
        repeat (DC + 1) tick();
        bus_write(2'd2, 32'h4);
        check_reg("coll_edge", 2'd2, 32'h5);
        check_reg("coll_count", 2'd3, 32'h2);
        in_port = 4'hF;
        repeat (15) tick();
        bus_write(2'd2, 32'hF);

        // COUNT write coincident with keys 0 and 3 pressing together
        in_port = 4'h6;
        repeat (DC + 1) tick();
        bus_write(2'd3, 32'h0);
        check_reg("coll_count2", 2'd3, 32'h2);
        check_reg("coll_data2", 2'd0, 32'h6);
        in_port = 4'hF;
        repeat (15) tick();

        // COUNT wrap after 256 presses
        bus_write(2'd3, 32'h0);
        for (int p = 0; p < 255; p++) begin
            in_port = 4'hE;
            repeat (12) tick();
            in_port = 4'hF;
            repeat (12) tick();
        end
        check_reg("count_255", 2'd3, 32'hFF);
        in_port = 4'hE;
        repeat (12) tick();
        in_port = 4'hF;
        repeat (12) tick();
        check_reg("count_wrap", 2'd3, 32'h0);

        // reset mid-debounce with key0 held through reset
        bus_write(2'd1, 32'hF);
        repeat (2) tick();
        check("pre_rst_irq", {31'h0, irq}, 32'h1);
        in_port = 4'hE;
        repeat (5) tick();
        reset_n = 1'b0;
        #2;
        check("mid_rst_readdata", readdata, 32'h0);
        check("mid_rst_irq", {31'h0, irq}, 32'h0);
        repeat (3) tick();
        reset_n = 1'b1;
        check_reg("post_rst_data", 2'd0, 32'hF);
        check_reg("post_rst_mask", 2'd1, 32'h0);
        check_reg("post_rst_edge", 2'd2, 32'h0);
        check_reg("post_rst_count", 2'd3, 32'h0);
        check("post_rst_irq", {31'h0, irq}, 32'h0);
        repeat (20) tick();
        check_reg("held_rst_count", 2'd3, 32'h1);
        check_reg("held_rst_edge", 2'd2, 32'h1);
        check_reg("held_rst_data", 2'd0, 32'hE);
        repeat (20) tick();
        check_reg("held_rst_once", 2'd3, 32'h1);

        // final report
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
